// File: rtl/pc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pc_pkg
// Purpose  : Shared types, defaults and helpers for the PC / fetch path.
// Revision : 1.0 - initial release
// ============================================================================
package pc_pkg;

  // Fetch FSM states.
  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    PEND = 2'd2
  } pc_state_t;

  // Default sequential increment in bytes (one 32-bit instruction).
  localparam int DEFAULT_STEP = 4;

  // Widest address the sign-extension helper supports.
  localparam int SEXT_W = 64;

  // Sign-extend the low 'width' bits of 'value' to SEXT_W bits. Callers
  // truncate the result to their own address width. Shifts are used instead
  // of variable bit selects so the helper is width-agnostic.
  function automatic logic [SEXT_W-1:0] sext(input logic [31:0] value,
                                             input int          width);
    logic [SEXT_W-1:0] result;
    logic [SEXT_W-1:0] mask;
    logic [31:0]       shifted;
    result  = {{(SEXT_W-32){1'b0}}, value};
    mask    = {SEXT_W{1'b1}} << width;
    shifted = value >> (width - 1);
    if (shifted[0]) begin
      result = result | mask;
    end else begin
      result = result & ~mask;
    end
    return result;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pc_target_calc.sv
`default_nettype none
// ============================================================================
// Module   : pc_target_calc
// Purpose  : Combinational redirect target: extend the selected immediate,
//            add it to the link address, or pass the register target.
// Revision : 1.0 - initial release
// ============================================================================
module pc_target_calc
  import pc_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] save_addr,
  input  logic [15:0]       imm16,
  input  logic [25:0]       imm26,
  input  logic [ADDR_W-1:0] reg_out,
  input  logic              branch,
  input  logic              regToPC,
  output logic [ADDR_W-1:0] tgt
);

  logic [ADDR_W-1:0] rel16;
  logic [ADDR_W-1:0] rel26;
  logic [ADDR_W-1:0] rel;
  logic [ADDR_W-1:0] rel_sum;

  // Both immediates are byte offsets; they are extended, never shifted.
  assign rel16 = ADDR_W'(sext({16'b0, imm16}, 16));
  assign rel26 = ADDR_W'(sext({6'b0, imm26}, 26));

  // Pick the offset, form the PC-relative sum (carry dropped), then let the
  // register-indirect request override everything.
  always_comb begin
    rel     = branch ? rel16 : rel26;
    rel_sum = save_addr + rel;
    tgt     = regToPC ? reg_out : rel_sum;
  end

endmodule
`default_nettype wire

// File: rtl/pc_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : pc_fetch_unit
// Purpose  : Program counter and instruction-fetch request generator with a
//            valid/ready handshake and a one-deep redirect buffer so that a
//            redirect arriving while a fetch is blocked is never lost.
// Revision : 1.0 - initial release
// ============================================================================
module pc_fetch_unit
  import pc_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                STEP     = DEFAULT_STEP
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [15:0]       imm16,
  input  logic [25:0]       imm26,
  input  logic [ADDR_W-1:0] reg_out,
  input  logic              branch,
  input  logic              leap,
  input  logic              regToPC,
  input  logic              stall,
  input  logic              imem_ready,
  output logic              imem_valid,
  output logic [ADDR_W-1:0] fetch_addr,
  output logic [ADDR_W-1:0] save_addr,
  output logic              flush,
  output logic              redirect_pending
);

  pc_state_t         state;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pend_tgt;
  logic [ADDR_W-1:0] tgt;
  logic              redir;
  logic              fire;
  logic              pc_free;

  // Request and handshake decode; the memory is only driven outside BOOT.
  always_comb begin
    imem_valid = (state != BOOT) & ~stall;
    fire       = imem_valid & imem_ready;
    redir      = leap | regToPC;
    // PC may move when no request is held frozen by a busy memory.
    pc_free    = fire | ~imem_valid;
    save_addr  = pc + ADDR_W'(STEP);
  end

  assign fetch_addr = pc;

  pc_target_calc #(
    .ADDR_W (ADDR_W)
  ) u_target_calc (
    .save_addr (save_addr),
    .imm16     (imm16),
    .imm26     (imm26),
    .reg_out   (reg_out),
    .branch    (branch),
    .regToPC   (regToPC),
    .tgt       (tgt)
  );

  // Fetch FSM: PC update, redirect buffering and registered status outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state            <= BOOT;
      pc               <= RESET_PC;
      pend_tgt         <= '0;
      flush            <= 1'b0;
      redirect_pending <= 1'b0;
    end else begin
      flush <= 1'b0;
      case (state)
        BOOT: begin
          state <= RUN;
          if (redir) begin
            pc    <= tgt;
            flush <= 1'b1;
          end
        end

        RUN: begin
          if (redir) begin
            if (pc_free) begin
              pc    <= tgt;
              flush <= 1'b1;
            end else begin
              // Request is frozen on the bus: park the target until it fires.
              pend_tgt         <= tgt;
              state            <= PEND;
              redirect_pending <= 1'b1;
            end
          end else if (fire) begin
            pc <= save_addr;
          end
        end

        PEND: begin
          if (pc_free) begin
            // A fresh redirect in the release cycle is newer than the buffer.
            pc               <= redir ? tgt : pend_tgt;
            flush            <= 1'b1;
            state            <= RUN;
            redirect_pending <= 1'b0;
          end else if (redir) begin
            pend_tgt <= tgt;
          end
        end

        default: begin
          state            <= BOOT;
          redirect_pending <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pc_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_pc_fetch_unit
// Purpose  : Directed, table-driven self-checking bench for pc_fetch_unit,
//            plus wrap instances (32-bit top-of-memory and 27-bit).
// Revision : 1.0 - initial release
// ============================================================================
module tb_pc_fetch_unit;

  typedef struct {
    logic        stall;
    logic        ready;
    logic        leap;
    logic        branch;
    logic        rtp;
    logic [15:0] imm16;
    logic [25:0] imm26;
    logic [31:0] reg_out;
    logic [31:0] e_addr;
    logic        e_valid;
    logic        e_flush;
    logic        e_pend;
  } vec_t;

  localparam int NVEC = 23;

  logic        clk;
  logic        reset;

  // Main instance (ADDR_W=32, RESET_PC=0)
  logic [15:0] imm16;
  logic [25:0] imm26;
  logic [31:0] reg_out;
  logic        branch, leap, regToPC, stall, imem_ready;
  logic        imem_valid, flush, redirect_pending;
  logic [31:0] fetch_addr, save_addr;

  // Top-of-memory wrap instance
  logic        w_valid, w_flush, w_pend;
  logic [31:0] w_addr, w_save;

  // 27-bit instance
  logic        a_stall, a_leap;
  logic [15:0] a_imm16;
  logic        a_valid, a_flush, a_pend;
  logic [26:0] a_addr, a_save;

  logic        zero1;
  logic        one1;
  logic [15:0] zero16;
  logic [25:0] zero26;
  logic [31:0] zero32;
  logic [26:0] zero27;

  int n_cmp;
  int n_err;

  vec_t vecs [NVEC];

  pc_fetch_unit #(.ADDR_W(32), .RESET_PC(32'h0), .STEP(4)) dut (
    .clk(clk), .reset(reset), .imm16(imm16), .imm26(imm26), .reg_out(reg_out),
    .branch(branch), .leap(leap), .regToPC(regToPC), .stall(stall),
    .imem_ready(imem_ready), .imem_valid(imem_valid), .fetch_addr(fetch_addr),
    .save_addr(save_addr), .flush(flush), .redirect_pending(redirect_pending)
  );

  pc_fetch_unit #(.ADDR_W(32), .RESET_PC(32'hFFFF_FFFC), .STEP(4)) dut_wrap (
    .clk(clk), .reset(reset), .imm16(zero16), .imm26(zero26), .reg_out(zero32),
    .branch(zero1), .leap(zero1), .regToPC(zero1), .stall(zero1),
    .imem_ready(one1), .imem_valid(w_valid), .fetch_addr(w_addr),
    .save_addr(w_save), .flush(w_flush), .redirect_pending(w_pend)
  );

  pc_fetch_unit #(.ADDR_W(27), .RESET_PC(27'h7FF_FFFC), .STEP(4)) dut_27 (
    .clk(clk), .reset(reset), .imm16(a_imm16), .imm26(zero26), .reg_out(zero27),
    .branch(one1), .leap(a_leap), .regToPC(zero1), .stall(a_stall),
    .imem_ready(one1), .imem_valid(a_valid), .fetch_addr(a_addr),
    .save_addr(a_save), .flush(a_flush), .redirect_pending(a_pend)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog
  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic vec(input int i,
                     input logic s, input logic r, input logic l, input logic b,
                     input logic rt, input logic [15:0] i16, input logic [25:0] i26,
                     input logic [31:0] ro, input logic [31:0] ea, input logic ev,
                     input logic ef, input logic ep);
    vecs[i] = '{s, r, l, b, rt, i16, i26, ro, ea, ev, ef, ep};
  endtask

  initial begin
    n_cmp = 0; n_err = 0;
    zero1 = 1'b0; one1 = 1'b1; zero16 = '0; zero26 = '0; zero32 = '0; zero27 = '0;
    imm16 = '0; imm26 = '0; reg_out = '0; branch = 0; leap = 0; regToPC = 0;
    stall = 0; imem_ready = 1; a_stall = 0; a_leap = 0; a_imm16 = 16'hFFF8;

    //     i  stl rdy lp br rt  imm16     imm26         reg_out       exp_addr     v  f  p
    vec( 0, 0, 1, 0, 0, 0, 16'h0,    26'h0,        32'h0,        32'h0,       0, 0, 0);
    vec( 1, 0, 1, 0, 0, 0, 16'h0,    26'h0,        32'h0,        32'h0,       1, 0, 0);
    vec( 2, 0, 1, 0, 0, 0, 16'h0,    26'h0,        32'h0,        32'h4,       1, 0, 0);
    vec( 3, 0, 1, 0, 0, 0, 16'h0,    26'h0,        32'h0,        32'h8,       1, 0, 0);
    vec( 4, 0, 1, 0, 0, 1, 16'h0,    26'h0,        32'h100,      32'hC,       1, 0, 0);
    vec( 5, 0, 1, 1, 1, 0, 16'hFFF8, 26'h0,        32'h0,        32'h100,     1, 1, 0);
    vec( 6, 0, 1, 1, 0, 1, 16'h0,    26'h3FF_FFFF, 32'h8000,     32'hFC,      1, 1, 0);
    vec( 7, 0, 1, 0, 0, 0, 16'h0,    26'h0,        32'h0,        32'h8000,    1, 1, 0);
    vec( 8, 0, 1, 0, 0, 1, 16'h0,    26'h0,        32'h40,       32'h8004,    1, 0, 0);
    vec( 9, 0, 0, 1, 0, 0, 16'h0,    26'h10,       32'h0,        32'h40,      1, 1, 0);
    vec(10, 0, 0, 1, 0, 0, 16'h0,    26'h20,       32'h0,        32'h40,      1, 0, 1);
    vec(11, 0, 1, 0, 0, 0, 16'h0,    26'h0,        32'h0,        32'h40,      1, 0, 1);
    vec(12, 0, 1, 0, 0, 0, 16'h0,    26'h0,        32'h0,        32'h64,      1, 1, 0);
    vec(13, 1, 1, 0, 0, 0, 16'h0,    26'h0,        32'h0,        32'h68,      0, 0, 0);
    vec(14, 1, 1, 0, 0, 0, 16'h0,    26'h0,        32'h0,        32'h68,      0, 0, 0);
    vec(15, 1, 1, 1, 1, 0, 16'h0010, 26'h0,        32'h0,        32'h68,      0, 0, 0);
    vec(16, 0, 0, 0, 0, 0, 16'h0,    26'h0,        32'h0,        32'h7C,      1, 1, 0);
    vec(17, 0, 0, 0, 0, 1, 16'h0,    26'h0,        32'h200,      32'h7C,      1, 0, 0);
    vec(18, 1, 0, 0, 0, 0, 16'h0,    26'h0,        32'h0,        32'h7C,      0, 0, 1);
    vec(19, 0, 0, 1, 0, 0, 16'h0,    26'h8,        32'h0,        32'h200,     1, 1, 0);
    vec(20, 0, 1, 1, 0, 0, 16'h0,    26'h4,        32'h0,        32'h200,     1, 0, 1);
    vec(21, 0, 0, 0, 0, 1, 16'h0,    26'h0,        32'h300,      32'h208,     1, 1, 0);
    vec(22, 0, 0, 0, 0, 0, 16'h0,    26'h0,        32'h0,        32'h208,     1, 0, 1);

    // Reset state
    reset = 1'b1;
    #3;
    chk("rst addr",  {32'h0, fetch_addr}, 64'h0);
    chk("rst save",  {32'h0, save_addr},  64'h4);
    chk("rst valid", {63'h0, imem_valid}, 64'h0);
    chk("rst flush", {63'h0, flush},      64'h0);
    chk("rst pend",  {63'h0, redirect_pending}, 64'h0);
    chk("wrap rst addr", {32'h0, w_addr}, 64'hFFFF_FFFC);
    chk("wrap rst save", {32'h0, w_save}, 64'h0);
    chk("w27 rst addr",  {37'h0, a_addr}, 64'h7FF_FFFC);
    chk("w27 rst save",  {37'h0, a_save}, 64'h0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Table: inputs applied, pre-edge outputs compared, then one clock edge.
    for (int i = 0; i < NVEC; i++) begin
      stall = vecs[i].stall; imem_ready = vecs[i].ready; leap = vecs[i].leap;
      branch = vecs[i].branch; regToPC = vecs[i].rtp; imm16 = vecs[i].imm16;
      imm26 = vecs[i].imm26; reg_out = vecs[i].reg_out;
      a_stall = (i >= 2);
      a_leap  = (i == 3);
      #1;
      chk($sformatf("v%0d addr", i),  {32'h0, fetch_addr}, {32'h0, vecs[i].e_addr});
      chk($sformatf("v%0d save", i),  {32'h0, save_addr},  {32'h0, vecs[i].e_addr + 32'h4});
      chk($sformatf("v%0d valid", i), {63'h0, imem_valid}, {63'h0, vecs[i].e_valid});
      chk($sformatf("v%0d flush", i), {63'h0, flush},      {63'h0, vecs[i].e_flush});
      chk($sformatf("v%0d pend", i),  {63'h0, redirect_pending}, {63'h0, vecs[i].e_pend});
      case (i)
        0: begin
          chk("wrap c0 valid", {63'h0, w_valid}, 64'h0);
          chk("w27 c0 addr",   {37'h0, a_addr},  64'h7FF_FFFC);
        end
        1: begin
          chk("wrap c1 addr",  {32'h0, w_addr},  64'hFFFF_FFFC);
          chk("wrap c1 valid", {63'h0, w_valid}, 64'h1);
        end
        2: begin
          chk("wrap c2 addr",  {32'h0, w_addr},  64'h0);
          chk("w27 c2 addr",   {37'h0, a_addr},  64'h0);
        end
        3: chk("w27 stall addr", {37'h0, a_addr}, 64'h0);
        4: begin
          chk("w27 br addr",  {37'h0, a_addr},  64'h7FF_FFFC);
          chk("w27 br flush", {63'h0, a_flush}, 64'h1);
        end
        5: chk("w27 br flush end", {63'h0, a_flush}, 64'h0);
        default: ;
      endcase
      @(posedge clk);
      #1;
    end

    // Reset while a redirect is parked: buffer discarded, no flush.
    #2 reset = 1'b1;
    #1;
    chk("pend rst addr",  {32'h0, fetch_addr}, 64'h0);
    chk("pend rst pend",  {63'h0, redirect_pending}, 64'h0);
    chk("pend rst flush", {63'h0, flush}, 64'h0);
    @(posedge clk);
    #1;
    chk("pend rst hold flush", {63'h0, flush}, 64'h0);
    chk("pend rst hold addr",  {32'h0, fetch_addr}, 64'h0);

    // Release with a register jump requested in BOOT.
    reset = 1'b0; stall = 0; imem_ready = 1; leap = 0; regToPC = 1; reg_out = 32'h500;
    #1;
    chk("boot valid", {63'h0, imem_valid}, 64'h0);
    chk("boot flush", {63'h0, flush}, 64'h0);
    @(posedge clk);
    #1;
    chk("boot redir addr",  {32'h0, fetch_addr}, 64'h500);
    chk("boot redir flush", {63'h0, flush}, 64'h1);
    chk("boot redir pend",  {63'h0, redirect_pending}, 64'h0);
    regToPC = 0;
    @(posedge clk);
    #1;
    chk("post boot addr",  {32'h0, fetch_addr}, 64'h504);
    chk("post boot flush", {63'h0, flush}, 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
